// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//  Definitions shared by the SPI mode-0 master TX and slave RX blocks.
//  SPI_DATA_W     : bits per SPI byte, MSB first
//  MIN_OVERSAMPLE : minimum In_clk cycles per SCLK period
//  spi_state_t    : receiver FSM encoding (ST_IDLE, ST_RECV)
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_DATA_W     = 8;
   localparam int MIN_OVERSAMPLE = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_slave_rx_mode0_if.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_mode0_if
//  SPI pins plus the received-byte bus of the mode-0 slave receiver.
//  In_spi_cs_n / In_spi_sclk / In_spi_mosi : SPI pins, driven by the master side
//  Out_rx_data  : last completed byte
//  Out_rx_valid : one-cycle pulse, Out_rx_data updated
//  Out_rx_busy  : frame open
//  Out_rx_err   : one-cycle pulse, frame closed mid-byte
//  modport slave  : receiver view (pins in, rx bus out)
//  modport master : driver/consumer view (pins out, rx bus in)
// ---------------------------------------------------------------------------
interface spi_slave_rx_mode0_if;
   import spi_pkg::*;

   logic                  In_spi_cs_n;
   logic                  In_spi_sclk;
   logic                  In_spi_mosi;
   logic [SPI_DATA_W-1:0] Out_rx_data;
   logic                  Out_rx_valid;
   logic                  Out_rx_busy;
   logic                  Out_rx_err;

   modport slave (
      input  In_spi_cs_n, In_spi_sclk, In_spi_mosi,
      output Out_rx_data, Out_rx_valid, Out_rx_busy, Out_rx_err
   );

   modport master (
      output In_spi_cs_n, In_spi_sclk, In_spi_mosi,
      input  Out_rx_data, Out_rx_valid, Out_rx_busy, Out_rx_err
   );

endinterface

// File: rtl/spi_slave_rx_mode0_sync.sv
// ---------------------------------------------------------------------------
// spi_sync_bit
//  Multi-flop synchronizer for one asynchronous input bit.
//  In_clk : system clock
//  In_rst : synchronous active-high reset, loads RST_VAL into every stage
//  In_d   : asynchronous input
//  Out_q  : synchronized output, STAGES cycles of delay
// ---------------------------------------------------------------------------
module spi_sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic In_clk,
   input  logic In_rst,
   input  logic In_d,
   output logic Out_q
);

   if (STAGES < 2) begin : g_bad_stages
      $fatal(1, "spi_sync_bit: STAGES must be >= 2");
   end

   logic [STAGES-1:0] sync_p0;

   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         sync_p0 <= {STAGES{RST_VAL}};
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], In_d};
      end
   end

   assign Out_q = sync_p0[STAGES-1];

endmodule

// File: rtl/spi_slave_rx_mode0.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_mode0
//  SPI mode-0 (CPOL=0, CPHA=0) slave receiver, 8-bit MSB first. The SPI pins
//  are oversampled in the In_clk domain, MOSI is shifted on each SCLK rise
//  while CS_N is low, and each completed byte is presented with a one-cycle
//  valid pulse. A frame closed part-way through a byte raises a one-cycle err.
//  In_clk : system clock
//  In_rst : synchronous active-high reset
//  bus    : spi_slave_rx_mode0_if.slave (SPI pins in, rx data/valid/busy/err out)
// ---------------------------------------------------------------------------
module spi_slave_rx_mode0
   import spi_pkg::*;
#(
   parameter int REF_CLK     = 50_000_000,
   parameter int SPI_SCLK    = 50_000,
   parameter int SYNC_STAGES = 2
) (
   input logic                 In_clk,
   input logic                 In_rst,
   spi_slave_rx_mode0_if.slave bus
);

   localparam int                CNT_W    = $clog2(SPI_DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPI_DATA_W - 1);

   if ((REF_CLK / SPI_SCLK) < MIN_OVERSAMPLE || SYNC_STAGES < 2) begin : g_bad_params
      $fatal(1, "spi_slave_rx_mode0: need REF_CLK/SPI_SCLK >= 8 and SYNC_STAGES >= 2");
   end

   // Stage p0: synchronizers (equal depth keeps MOSI aligned with SCLK)
   logic cs_s, sclk_s, mosi_s;

   spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .In_clk(In_clk), .In_rst(In_rst), .In_d(bus.In_spi_cs_n), .Out_q(cs_s)
   );
   spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .In_clk(In_clk), .In_rst(In_rst), .In_d(bus.In_spi_sclk), .Out_q(sclk_s)
   );
   spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .In_clk(In_clk), .In_rst(In_rst), .In_d(bus.In_spi_mosi), .Out_q(mosi_s)
   );

   // Stage p1: edge detect, FSM, bit counter, shift register
   logic cs_d, sclk_d;
   logic sclk_rise, cs_fall, cs_rise;

   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         cs_d   <= 1'b1;
         sclk_d <= 1'b0;
      end else begin
         cs_d   <= cs_s;
         sclk_d <= sclk_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cs_rise   = cs_s & ~cs_d;

   spi_state_t            state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [SPI_DATA_W-1:0] shift_q;
   logic                  cnt_clr, shift_en, err_set, byte_done;
   logic                  vld_p1;

   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      err_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_RECV;
               cnt_clr = 1'b1;
            end
         end
         ST_RECV: begin
            // cs_rise wins over a coincident SCLK edge; that edge is dropped
            if (cs_rise) begin
               state_d = ST_IDLE;
               err_set = (bit_cnt_q != '0);
            end else if (sclk_rise && !cs_s) begin
               shift_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign byte_done = shift_en && (bit_cnt_q == CNT_LAST);

   // bit_cnt wraps 7->0 on byte completion so CS_N may stay low across bytes;
   // the shift register is never cleared since 8 edges flush it completely.
   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         vld_p1    <= 1'b0;
      end else begin
         vld_p1 <= byte_done;
         if (cnt_clr) begin
            bit_cnt_q <= '0;
         end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
         end
         if (shift_en) begin
            shift_q <= {shift_q[SPI_DATA_W-2:0], mosi_s};
         end
      end
   end

   // Stage p2: output registers
   logic [SPI_DATA_W-1:0] rx_data_p2;
   logic                  rx_valid_p2, rx_err_p2;

   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         rx_data_p2  <= '0;
         rx_valid_p2 <= 1'b0;
         rx_err_p2   <= 1'b0;
      end else begin
         rx_valid_p2 <= vld_p1;
         rx_err_p2   <= err_set;
         if (vld_p1) begin
            rx_data_p2 <= shift_q;
         end
      end
   end

   assign bus.Out_rx_data  = rx_data_p2;
   assign bus.Out_rx_valid = rx_valid_p2;
   assign bus.Out_rx_err   = rx_err_p2;
   assign bus.Out_rx_busy  = (state_q == ST_RECV);

endmodule

// File: tb/tb_spi_slave_rx_mode0.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx_mode0
//  Directed bench for spi_slave_rx_mode0: the bench plays the mode-0 master,
//  drives frames on the negative clock edge and samples DUT outputs there.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx_mode0;

   localparam int SYNC = 3;

   logic In_clk = 1'b0;
   logic In_rst = 1'b1;
   int   cyc    = 0;

   always #10 In_clk = ~In_clk;   // 50 MHz
   always @(posedge In_clk) cyc <= cyc + 1;

   spi_slave_rx_mode0_if bus ();

   spi_slave_rx_mode0 #(
      .REF_CLK(50_000_000), .SPI_SCLK(50_000), .SYNC_STAGES(SYNC)
   ) dut (
      .In_clk(In_clk),
      .In_rst(In_rst),
      .bus   (bus)
   );

   int       n_tests = 0;
   int       n_fail  = 0;
   int       n_valid = 0;
   int       n_err   = 0;
   int       n_both  = 0;
   int       valid_cyc = 0;
   int       rise_cyc  = 0;
   logic [7:0] last_data = 8'h00;
   logic     busy_seen = 1'b0;

   always @(negedge In_clk) begin
      if (bus.Out_rx_valid) begin
         n_valid   = n_valid + 1;
         last_data = bus.Out_rx_data;
         valid_cyc = cyc;
      end
      if (bus.Out_rx_err) n_err = n_err + 1;
      if (bus.Out_rx_valid && bus.Out_rx_err) n_both = n_both + 1;
      if (bus.Out_rx_busy) busy_seen = 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge In_clk);
   endtask

   // Opens (or continues) a frame and clocks out the top nbits of b, MSB first.
   task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
      bus.In_spi_cs_n = 1'b0;
      tick(half);
      for (int i = 0; i < nbits; i++) begin
         bus.In_spi_mosi = b[7-i];
         tick(half);
         bus.In_spi_sclk = 1'b1;
         rise_cyc        = cyc;
         tick(half);
         bus.In_spi_sclk = 1'b0;
      end
   endtask

   task automatic close_frame(input int half);
      tick(half);
      bus.In_spi_cs_n = 1'b1;
      tick(2 * half + 12);
   endtask

   int v0, e0;

   initial begin
      bus.In_spi_cs_n = 1'b1;
      bus.In_spi_sclk = 1'b0;
      bus.In_spi_mosi = 1'b0;
      tick(5);
      check_eq("rst_data",  bus.Out_rx_data,  8'h00);
      check_eq("rst_valid", bus.Out_rx_valid, 1'b0);
      check_eq("rst_busy",  bus.Out_rx_busy,  1'b0);
      check_eq("rst_err",   bus.Out_rx_err,   1'b0);
      In_rst = 1'b0;
      tick(5);

      // Single frame at 50 kHz SCLK
      send_bits(8'hA5, 8, 500);
      check_eq("a5_busy_in", bus.Out_rx_busy, 1'b1);
      close_frame(500);
      check_eq("a5_valid_cnt", n_valid, 1);
      check_eq("a5_data", last_data, 8'hA5);
      check_eq("a5_err_cnt", n_err, 0);
      check_eq("a5_busy_out", bus.Out_rx_busy, 1'b0);

      // Two bytes with CS_N held low
      send_bits(8'h3C, 8, 4);
      tick(8);
      check_eq("3c_data", last_data, 8'h3C);
      send_bits(8'hC3, 8, 4);
      close_frame(4);
      check_eq("3cc3_valid_cnt", n_valid, 3);
      check_eq("c3_data", bus.Out_rx_data, 8'hC3);
      check_eq("3cc3_err_cnt", n_err, 0);

      // Abort after 3 bits
      send_bits(8'hF0, 3, 4);
      close_frame(4);
      check_eq("abort_err_cnt", n_err, 1);
      check_eq("abort_valid_cnt", n_valid, 3);
      check_eq("abort_data_hold", bus.Out_rx_data, 8'hC3);
      send_bits(8'h81, 8, 4);
      close_frame(4);
      check_eq("81_data", last_data, 8'h81);
      check_eq("81_valid_cnt", n_valid, 4);

      // Reset after 4 bits
      send_bits(8'h5A, 4, 4);
      tick(2);
      In_rst = 1'b1;
      tick(1);
      check_eq("mid_rst_data",  bus.Out_rx_data,  8'h00);
      check_eq("mid_rst_valid", bus.Out_rx_valid, 1'b0);
      check_eq("mid_rst_busy",  bus.Out_rx_busy,  1'b0);
      check_eq("mid_rst_err",   bus.Out_rx_err,   1'b0);
      bus.In_spi_cs_n = 1'b1;
      In_rst = 1'b0;
      tick(20);
      check_eq("mid_rst_err_cnt", n_err, 1);
      send_bits(8'hFF, 8, 4);
      close_frame(4);
      check_eq("ff_data", last_data, 8'hFF);
      check_eq("ff_valid_cnt", n_valid, 5);

      // SCLK toggling with CS_N high
      busy_seen = 1'b0;
      v0 = n_valid;
      e0 = n_err;
      for (int i = 0; i < 16; i++) begin
         bus.In_spi_mosi = 1'($urandom_range(0, 1));
         tick(4);
         bus.In_spi_sclk = 1'b1;
         tick(4);
         bus.In_spi_sclk = 1'b0;
      end
      tick(20);
      check_eq("csh_valid", n_valid - v0, 0);
      check_eq("csh_err",   n_err - e0, 0);
      check_eq("csh_busy",  busy_seen, 1'b0);

      // Master-style byte at ratio 8, latency from the 8th SCLK rise
      send_bits(8'h96, 8, 4);
      close_frame(4);
      check_eq("96_data", last_data, 8'h96);
      check_eq("96_latency", valid_cyc - rise_cyc, SYNC + 2);

      // CS_N rises one cycle after the 8th SCLK rise: valid, no err
      e0 = n_err;
      send_bits(8'h69, 7, 4);
      bus.In_spi_mosi = 1'b1;
      tick(4);
      bus.In_spi_sclk = 1'b1;
      tick(1);
      bus.In_spi_cs_n = 1'b1;
      tick(3);
      bus.In_spi_sclk = 1'b0;
      tick(20);
      check_eq("69_data", last_data, 8'h69);
      check_eq("69_err", n_err - e0, 0);
      check_eq("valid_err_overlap", n_both, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
